// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: state encodings, widths and helpers shared by the divide sequencer.
package div_ctrl_pkg;
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;
    localparam int DIV_RES_WD   = 64;
    localparam int EX_TO_DIV_WD = 1 + 1 + 32 + 32;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
        return (s & v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (33-bit trial subtract and select).
module div_step (
    input  logic [31:0] i_rem,
    input  logic        i_msb,
    input  logic [31:0] i_dsr,
    output logic [31:0] o_rem,
    output logic        o_qbit
);
    logic [32:0] w_diff;
    assign w_diff = {i_rem, i_msb} - {1'b0, i_dsr};
    assign o_qbit = ~w_diff[32];
    assign o_rem  = o_qbit ? w_diff[31:0] : {i_rem[30:0], i_msb};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer with pipeline stall request.
// Define DIV_ZERO_FAST_EN to finish zero-divisor operations in 2 cycles.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [31:0]           opdata1_i,
    input  logic [31:0]           opdata2_i,
    input  logic                  annul_i,
    output logic [DIV_RES_WD-1:0] result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);
    div_state_e              r_state, w_next;
    logic [4:0]              r_cnt;
    logic                    r_neg, r_rsign;
    logic [31:0]             r_dvd, r_dsr, r_rem, r_quo, r_op1;
    logic [DIV_RES_WD-1:0]   r_result, w_final;
    logic [EX_TO_DIV_WD-1:0] w_req;
    logic [31:0]             w_rem, w_quo, w_op1, w_op2;
    logic                    w_qbit, w_sgn, w_accept, w_dz;

    assign w_req    = {start_i, signed_i, opdata1_i, opdata2_i};
    assign w_sgn    = w_req[64];
    assign w_op1    = w_req[63:32];
    assign w_op2    = w_req[31:0];
    assign w_accept = w_req[65] & ~annul_i;
`ifdef DIV_ZERO_FAST_EN
    assign w_dz = (w_op2 == '0);
`else
    assign w_dz = 1'b0;
`endif

    div_step u_step (
        .i_rem  (r_rem),
        .i_msb  (r_dvd[31]),
        .i_dsr  (r_dsr),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    assign w_quo = {r_quo[30:0], w_qbit};
    // A zero divisor reports the raw dividend and all-ones quotient, unfixed.
    assign w_final = (r_dsr == '0) ? {r_op1, 32'hFFFF_FFFF}
                   : {r_rsign ? -w_rem : w_rem, r_neg ? -w_quo : w_quo};

    always_comb begin
        w_next = r_state;
        case (r_state)
            DivFree:   w_next = w_accept ? (w_dz ? DivByZero : DivOn) : DivFree;
            DivByZero: w_next = DivEnd;
            DivOn:     w_next = (r_cnt == 5'd31) ? DivEnd : DivOn;
            DivEnd:    w_next = start_i ? DivEnd : DivFree;
        endcase
        if (annul_i) w_next = DivFree;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_rsign  <= 1'b0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_op1    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_next;
            r_result <= (w_next == DivEnd) ? ((r_state == DivEnd) ? r_result : w_final) : '0;
            if (r_state == DivFree) begin
                r_cnt   <= '0;
                r_neg   <= (w_op1[31] ^ w_op2[31]) & w_sgn;
                r_rsign <= w_op1[31] & w_sgn;
                r_dvd   <= abs32(w_op1, w_sgn);
                r_dsr   <= abs32(w_op2, w_sgn);
                r_rem   <= '0;
                r_quo   <= '0;
                r_op1   <= w_op1;
            end else if (r_state == DivOn) begin
                r_cnt <= r_cnt + 5'd1;
                r_dvd <= {r_dvd[30:0], 1'b0};
                r_rem <= w_rem;
                r_quo <= w_quo;
            end
        end
    end

    assign result_o   = r_result;
    assign ready_o    = (r_state == DivEnd);
    assign stallreq_o = ((r_state == DivFree) & w_accept) | (r_state == DivByZero) | (r_state == DivOn);
endmodule
